// File: rtl/bit_ser_pkg.sv
// Shared types and constants for the bit serializer.
// Holds the FSM encoding, default word width and counter sizing helper.
package bit_ser_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int BIT_SER_WIDTH = 8;

  function automatic int cnt_width(input int frame);
    return (frame <= 2) ? 1 : $clog2(frame);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end feeding the serial "101" detector.
// Optional even-parity slot compiled in with BIT_SER_PARITY_EN.
module bit_serializer
  import bit_ser_pkg::*;
#(
  parameter int WIDTH     = BIT_SER_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

`ifdef BIT_SER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = cnt_width(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_shift;
  logic             at_last;
  logic             accept;
  logic             data_bit;
  logic             line_bit;
  logic [WIDTH-1:0] shifted;

  assign in_shift = (state_q == ST_SHIFT);
  assign at_last  = in_shift && (cnt_q == LAST);

  assign din_ready = ~rst & (~in_shift | at_last);
  assign accept    = din_valid & din_ready;

  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  assign data_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

`ifdef BIT_SER_PARITY_EN
  logic par_q, par_d;

  // Parity is latched with the word so later din changes cannot leak in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  always_comb begin
    par_d = par_q;
    if (accept) par_d = ^din;
  end

  assign line_bit = at_last ? par_q : data_bit;
`else
  assign line_bit = data_bit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!at_last) begin
          shreg_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end else if (accept) begin
          shreg_d = din;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign sout       = in_shift & line_bit;
  assign sout_valid = in_shift;
  assign busy       = in_shift;
  assign sout_last  = at_last;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (MSB-first and LSB-first instances).
// Parity slot expectations follow BIT_SER_PARITY_EN.
module tb_bit_serializer;

`ifdef BIT_SER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = 8 + (PAR ? 1 : 0);

  logic       clk;
  logic       rst;
  logic [7:0] din_m;
  logic       vld_m;
  logic       rdy_m;
  logic       sout_m;
  logic       sv_m;
  logic       sl_m;
  logic       busy_m;
  logic [7:0] din_l;
  logic       vld_l;
  logic       rdy_l;
  logic       sout_l;
  logic       sv_l;
  logic       sl_l;
  logic       busy_l;
  logic [1:0] dst;
  logic       det;

  int n_cmp;
  int n_err;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .din        (din_m),
    .din_valid  (vld_m),
    .din_ready  (rdy_m),
    .sout       (sout_m),
    .sout_valid (sv_m),
    .sout_last  (sl_m),
    .busy       (busy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din_l),
    .din_valid  (vld_l),
    .din_ready  (rdy_l),
    .sout       (sout_l),
    .sout_valid (sv_l),
    .sout_last  (sl_l),
    .busy       (busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Moore "101" detector on the LSB-first line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dst <= 2'd0;
    else begin
      unique case (dst)
        2'd0: dst <= sout_l ? 2'd1 : 2'd0;
        2'd1: dst <= sout_l ? 2'd1 : 2'd2;
        2'd2: dst <= sout_l ? 2'd3 : 2'd0;
        2'd3: dst <= sout_l ? 2'd1 : 2'd2;
      endcase
    end
  end
  assign det = (dst == 2'd3);

  task automatic chk(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sout"}, sout_m, 1'b0);
    chk({tag, "_svld"}, sv_m, 1'b0);
    chk({tag, "_busy"}, busy_m, 1'b0);
    chk({tag, "_last"}, sl_m, 1'b0);
    chk({tag, "_rdy"}, rdy_m, 1'b1);
  endtask

  // s is the data stream in send order, left to right.
  task automatic run_frame(input string tag, input logic [7:0] s,
                           input logic p);
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("%s_b%0d", tag, i), sout_m, (i < 8) ? s[7-i] : p);
      chk($sformatf("%s_v%0d", tag, i), sv_m, 1'b1);
      chk($sformatf("%s_l%0d", tag, i), sl_m, i == FRAME - 1);
      chk($sformatf("%s_r%0d", tag, i), rdy_m, i == FRAME - 1);
      tick();
    end
  endtask

  task automatic send(input string tag, input logic [7:0] w,
                      input logic [7:0] s, input logic p);
    din_m = w;
    vld_m = 1'b1;
    tick();
    vld_m = 1'b0;
    run_frame(tag, s, p);
    chk_idle({tag, "_end"});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    din_m = 8'h00;
    vld_m = 1'b0;
    din_l = 8'h00;
    vld_l = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sout", sout_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    chk("rst_svld", sv_m, 1'b0);
    chk("rst_last", sl_m, 1'b0);
    chk("rst_rdy", rdy_m, 1'b0);
    rst = 1'b0;
    #1;
    chk_idle("rel");

    vld_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle($sformatf("stall%0d", i));
    end

    send("a5", 8'hA5, 8'b1010_0101, 1'b0);

    din_m = 8'hA0;
    vld_m = 1'b1;
    tick();
    din_m = 8'h05;
    run_frame("b2b0", 8'b1010_0000, 1'b0);
    vld_m = 1'b0;
    run_frame("b2b1", 8'b0000_0101, 1'b0);
    chk_idle("b2b_end");

    din_m = 8'hFF;
    vld_m = 1'b1;
    tick();
    vld_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ff_b%0d", i), sout_m, 1'b1);
      tick();
    end
    chk("ff_b3_pre", sout_m, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_sout", sout_m, 1'b0);
    chk("mid_busy", busy_m, 1'b0);
    chk("mid_svld", sv_m, 1'b0);
    chk("mid_rdy", rdy_m, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk_idle("rel2");
    send("0f", 8'h0F, 8'b0000_1111, 1'b0);

    send("07", 8'h07, 8'b0000_0111, 1'b1);
    send("03", 8'h03, 8'b0000_0011, 1'b0);

    din_l = 8'h01;
    vld_l = 1'b1;
    tick();
    vld_l = 1'b0;
    for (int i = 0; i < FRAME + 3; i++) begin
      chk($sformatf("lsb_b%0d", i), sout_l,
          (i == 0) || (PAR && i == FRAME - 1));
      chk($sformatf("lsb_v%0d", i), sv_l, i < FRAME);
      chk($sformatf("det%0d", i), det, 1'b0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
